wb_rr_arbiter: RTL and testbench

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_rr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS pipelined masters share one slave,
// with an outstanding-strobe cap and a response timeout that aborts the grant.

module wb_rr_lane (
  input  logic sel,
  input  logic granted,
  input  logic aborting,
  input  logic s_ack,
  input  logic s_err,
  input  logic s_stall,
  input  logic limit,
  input  logic has_out,
  output logic ack,
  output logic err,
  output logic stall
);
  logic own;
  assign own   = granted & sel;
  assign ack   = own & s_ack & has_out;
  assign err   = (own & s_err & has_out) | (aborting & sel);
  assign stall = ~own | s_stall | limit;
endmodule

module wb_rr_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT         = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_MASTERS-1:0]          m_cyc_i,
  input  logic [NUM_MASTERS-1:0]          m_stb_i,
  input  logic [NUM_MASTERS-1:0]          m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [DATA_WIDTH-1:0]           m_dat_o,
  output logic [NUM_MASTERS-1:0]          m_ack_o,
  output logic [NUM_MASTERS-1:0]          m_err_o,
  output logic [NUM_MASTERS-1:0]          m_stall_o,
  output logic                            s_cyc_o,
  output logic                            s_stb_o,
  output logic                            s_we_o,
  output logic [ADDR_WIDTH-1:0]           s_adr_o,
  output logic [DATA_WIDTH-1:0]           s_dat_o,
  input  logic [DATA_WIDTH-1:0]           s_dat_i,
  input  logic                            s_ack_i,
  input  logic                            s_err_i,
  input  logic                            s_stall_i,
  output logic [NUM_MASTERS-1:0]          gnt_o,
  output logic                            timeout_o
);
  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int TMO_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANTED, ABORT} state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] g, g_n, p, p_n, pick, idx, g_inc;
  logic [OUT_W-1:0] out_cnt, out_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_n;
  logic             any_req, granted, aborting, limit, has_out, accept, fwd;

  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] adr_v;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] dat_v;
  assign adr_v = m_adr_i;
  assign dat_v = m_dat_i;

  // Outputs are forced to their idle values while reset is held, not just after the edge.
  assign granted  = (state == GRANTED) & ~rst_i;
  assign aborting = (state == ABORT) & ~rst_i;
  assign limit    = (out_cnt == OUT_W'(MAX_OUTSTANDING));
  assign has_out  = (out_cnt != '0);
  assign g_inc    = IDX_W'((int'(g) + 1) % NUM_MASTERS);

  assign s_cyc_o   = granted;
  assign s_stb_o   = granted & m_stb_i[g] & ~limit;
  assign s_we_o    = m_we_i[g];
  assign s_adr_o   = adr_v[g];
  assign s_dat_o   = dat_v[g];
  assign m_dat_o   = s_dat_i;
  assign gnt_o     = granted ? (NUM_MASTERS'(1) << g) : '0;
  assign timeout_o = aborting;

  assign accept = s_stb_o & ~s_stall_i;
  assign fwd    = (s_ack_i | s_err_i) & has_out;

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_lane
    wb_rr_lane u_lane (
      .sel     (g == IDX_W'(k)),
      .granted (granted),
      .aborting(aborting),
      .s_ack   (s_ack_i),
      .s_err   (s_err_i),
      .s_stall (s_stall_i),
      .limit   (limit),
      .has_out (has_out),
      .ack     (m_ack_o[k]),
      .err     (m_err_o[k]),
      .stall   (m_stall_o[k])
    );
  end

  // First requester at or above the round-robin pointer, wrapping.
  always_comb begin
    pick    = p;
    idx     = '0;
    any_req = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = IDX_W'((int'(p) + i) % NUM_MASTERS);
      if (!any_req && m_cyc_i[idx]) begin
        any_req = 1'b1;
        pick    = idx;
      end
    end
  end

  always_comb begin
    state_n = state;
    g_n     = g;
    p_n     = p;
    out_n   = out_cnt;
    tmo_n   = '0;
    case (state)
      IDLE: begin
        out_n = '0;
        if (any_req) begin
          g_n     = pick;
          state_n = GRANTED;
        end
      end
      GRANTED: begin
        if (!m_cyc_i[g]) begin
          state_n = IDLE;
          p_n     = g_inc;
          out_n   = '0;
        end else if (has_out && tmo_cnt == TMO_W'(TIMEOUT - 1) && !s_ack_i && !s_err_i) begin
          state_n = ABORT;
        end else begin
          if (accept && !fwd)      out_n = out_cnt + 1'b1;
          else if (!accept && fwd) out_n = out_cnt - 1'b1;
          if (has_out && !s_ack_i && !s_err_i) tmo_n = tmo_cnt + 1'b1;
        end
      end
      ABORT: begin
        state_n = IDLE;
        p_n     = g_inc;
        out_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      g       <= '0;
      p       <= '0;
      out_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_n;
      g       <= g_n;
      p       <= p_n;
      out_cnt <= out_n;
      tmo_cnt <= tmo_n;
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: a per-cycle vector table plus hand sequences
// for round robin, outstanding limit, timeout, simultaneous events and reset.

module tb_wb_rr_arbiter;
  localparam int N = 4, AW = 16, DW = 32;

  logic clk = 1'b0;
  logic rst_i;
  logic [N-1:0] m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [DW-1:0] m_dat_o, s_dat_o, s_dat_i;
  logic [N-1:0] m_ack_o, m_err_o, m_stall_o, gnt_o;
  logic s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_stall_i, timeout_o;
  logic [AW-1:0] s_adr_o;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                  .MAX_OUTSTANDING(8), .TIMEOUT(64)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_stall_i(s_stall_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic       rst;
    logic [3:0] cyc, stb;
    logic       ack, err, stall;
    logic       e_cyc, e_stb;
    logic [3:0] e_gnt, e_ack, e_err, e_stall;
  } vec_t;

  vec_t vt[16];
  logic [AW-1:0] adr_k[N];
  logic [DW-1:0] dat_k[N];
  logic [N-1:0]  we_k;
  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic [3:0] c, input logic [3:0] s,
                     input logic a, input logic e, input logic st);
    @(negedge clk);
    rst_i = r; m_cyc = c; m_stb = s; s_ack_i = a; s_err_i = e; s_stall_i = st;
    #1;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " s_cyc"}, s_cyc_o, 1'b0);
    chk({nm, " s_stb"}, s_stb_o, 1'b0);
    chk({nm, " gnt"}, gnt_o, 4'b0000);
    chk({nm, " ack"}, m_ack_o, 4'b0000);
    chk({nm, " stall"}, m_stall_o, 4'b1111);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, lat;
    for (int k = 0; k < N; k++) begin
      adr_k[k] = AW'(4 * k);
      dat_k[k] = (k == 1) ? 32'hDEAD_BEEF : (32'hA5A5_0000 | DW'(k));
      m_adr[k*AW +: AW] = adr_k[k];
      m_dat[k*DW +: DW] = dat_k[k];
    end
    we_k = 4'b0010;
    m_we = we_k;
    s_dat_i = 32'h1234_5678;
    rst_i = 1'b1; m_cyc = '0; m_stb = '0; s_ack_i = 0; s_err_i = 0; s_stall_i = 0;

    //        rst cyc      stb      ack err stl  cyc stb gnt      ack      err      stall
    vt[0]  = '{1, 4'b0000, 4'b0000, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    vt[1]  = '{0, 4'b0000, 4'b0000, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    vt[2]  = '{0, 4'b0010, 4'b0010, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    vt[3]  = '{0, 4'b0010, 4'b0010, 1, 0, 0,   1, 1, 4'b0010, 4'b0000, 4'b0000, 4'b1101};
    vt[4]  = '{0, 4'b0010, 4'b0000, 1, 0, 0,   1, 0, 4'b0010, 4'b0010, 4'b0000, 4'b1101};
    vt[5]  = '{0, 4'b0000, 4'b0000, 0, 0, 0,   1, 0, 4'b0010, 4'b0000, 4'b0000, 4'b1101};
    vt[6]  = '{0, 4'b0001, 4'b0000, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    vt[7]  = '{0, 4'b0001, 4'b0001, 0, 0, 1,   1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b1111};
    vt[8]  = '{0, 4'b0001, 4'b0001, 0, 0, 0,   1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b1110};
    vt[9]  = '{0, 4'b0001, 4'b0000, 0, 1, 0,   1, 0, 4'b0001, 4'b0000, 4'b0001, 4'b1110};
    vt[10] = '{0, 4'b0000, 4'b0000, 0, 0, 0,   1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b1110};
    vt[11] = '{0, 4'b1001, 4'b0000, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    vt[12] = '{0, 4'b1001, 4'b0000, 0, 0, 0,   1, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0111};
    vt[13] = '{0, 4'b0001, 4'b0000, 0, 0, 0,   1, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0111};
    vt[14] = '{0, 4'b0001, 4'b0000, 0, 0, 0,   0, 0, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    vt[15] = '{0, 4'b0001, 4'b0000, 0, 0, 0,   1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b1110};

    for (int i = 0; i < 16; i++) begin
      drv(vt[i].rst, vt[i].cyc, vt[i].stb, vt[i].ack, vt[i].err, vt[i].stall);
      chk($sformatf("v%0d s_cyc", i), s_cyc_o, vt[i].e_cyc);
      chk($sformatf("v%0d s_stb", i), s_stb_o, vt[i].e_stb);
      chk($sformatf("v%0d gnt", i), gnt_o, vt[i].e_gnt);
      chk($sformatf("v%0d ack", i), m_ack_o, vt[i].e_ack);
      chk($sformatf("v%0d err", i), m_err_o, vt[i].e_err);
      chk($sformatf("v%0d stall", i), m_stall_o, vt[i].e_stall);
      chk($sformatf("v%0d tmo", i), timeout_o, 1'b0);
      if (vt[i].e_cyc) begin
        for (int k = 0; k < N; k++) if (vt[i].e_gnt[k]) begin
          chk($sformatf("v%0d adr", i), s_adr_o, adr_k[k]);
          chk($sformatf("v%0d dat", i), s_dat_o, dat_k[k]);
          chk($sformatf("v%0d we", i), s_we_o, we_k[k]);
        end
      end
    end
    chk("m_dat_o", m_dat_o, 32'h1234_5678);

    // ack plus a new accept in one cycle leaves exactly one response owed
    drv(0, 4'b0001, 4'b0001, 0, 0, 0); chk("sim accept", s_stb_o, 1'b1);
    drv(0, 4'b0001, 4'b0001, 1, 0, 0); chk("sim ack+acc", m_ack_o, 4'b0001);
    drv(0, 4'b0001, 4'b0000, 1, 0, 0); chk("sim ack2", m_ack_o, 4'b0001);
    drv(0, 4'b0001, 4'b0000, 1, 0, 0); chk("sim ack3 drop", m_ack_o, 4'b0000);
    drv(0, 4'b0000, 4'b0000, 0, 0, 0);
    // reset mid-burst on master 2 with pointer at 1
    drv(0, 4'b0100, 4'b0000, 0, 0, 0); chk_idle("pre gnt2");
    drv(0, 4'b0100, 4'b0100, 0, 0, 0); chk("burst gnt", gnt_o, 4'b0100);
    drv(1, 4'b0100, 4'b0100, 0, 0, 0); chk_idle("in rst");
    chk("in rst err", m_err_o, 4'b0000);
    chk("in rst tmo", timeout_o, 1'b0);
    drv(0, 4'b1111, 4'b0000, 0, 0, 0); chk_idle("post rst");
    drv(0, 4'b1111, 4'b0000, 0, 0, 0); chk("post rst gnt", gnt_o, 4'b0001);

    // round robin, each master drops cyc for one cycle once granted
    drv(1, 4'b0000, 4'b0000, 0, 0, 0);
    for (int j = 0; j < 5; j++) begin
      logic [3:0] one;
      one = 4'b0001 << (j % 4);
      drv(0, 4'b1111, 4'b0000, 0, 0, 0); chk($sformatf("rr%0d gap", j), s_cyc_o, 1'b0);
      drv(0, 4'b1111 & ~one, 4'b0000, 0, 0, 0); chk($sformatf("rr%0d gnt", j), gnt_o, one);
    end

    // outstanding limit: 10 strobes, no ack
    drv(1, 4'b0000, 4'b0000, 0, 0, 0);
    drv(0, 4'b0001, 4'b0000, 0, 0, 0);
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      drv(0, 4'b0001, 4'b0001, 0, 0, 0);
      chk($sformatf("lim%0d stb", i), s_stb_o, (i < 8));
      chk($sformatf("lim%0d stall", i), m_stall_o[0], (i >= 8));
      if (s_stb_o && !s_stall_i) acc++;
    end
    chk("lim accepted", acc, 8);

    // timeout: one outstanding on master 1, never acked
    drv(1, 4'b0000, 4'b0000, 0, 0, 0);
    drv(0, 4'b0010, 4'b0000, 0, 0, 0);
    drv(0, 4'b0010, 4'b0010, 0, 0, 0); chk("tmo accept", s_stb_o, 1'b1);
    lat = 101;
    for (int k = 1; k <= 100; k++) begin
      drv(0, 4'b0010, 4'b0000, 0, 0, 0);
      if (timeout_o) begin lat = k; break; end
    end
    chk("tmo latency", lat, 65);
    chk("tmo err", m_err_o, 4'b0010);
    chk("tmo s_cyc", s_cyc_o, 1'b0);
    drv(0, 4'b0111, 4'b0000, 0, 0, 0);
    chk("tmo pulse end", timeout_o, 1'b0);
    chk("tmo err end", m_err_o, 4'b0000);
    chk_idle("after abort");
    drv(0, 4'b0111, 4'b0000, 0, 0, 0); chk("tmo next gnt", gnt_o, 4'b0100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
